// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared types and helpers for the bit-register 7-segment display block.
//   - op_t    : command opcodes (WRITE / SET / CLEAR / TOGGLE)
//   - state_t : command handshake FSM states
//   - hex7()  : nibble -> active-low {a,b,c,d,e,f,g} segment pattern
package seg7_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Active-low segments, bit order {a,b,c,d,e,f,g}; lowercase b/d glyphs.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan
//   Display refresh scanner: a free-running DIV_BITS-wide prescaler whose
//   terminal count advances the active digit index modulo DIGITS, plus the
//   one-hot active-low anode decode.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   digit_idx   : currently active digit (0..DIGITS-1)
//   an          : active-low one-hot digit enables
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int DIV_BITS = 16,
  localparam int IDXW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [IDXW-1:0]   digit_idx,
  output logic [DIGITS-1:0] an
);

  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [IDXW-1:0]     idx_q, idx_d;

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    // Advance only on the prescaler's all-ones count; wrap at the last digit.
    if (&presc_q) begin
      if (idx_q == IDXW'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign digit_idx = idx_q;
  assign an        = ~(DIGITS'(1) << idx_q);

endmodule

// File: rtl/seg7_bitreg_display.sv
// seg7_bitreg_display
//   Bit-addressable W=4*DIGITS register updated by valid/ready commands, with
//   a fixed IDLE -> BUSY -> DONE handshake, shown on a time-multiplexed hex
//   7-segment display.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   valid_in     : command request (accepted when ready_out is high)
//   ready_out    : high only in IDLE
//   op           : 00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
//   bit_index    : target bit; indices >= W leave the register unchanged
//   bit_value    : data for WRITE
//   valid_out    : one-cycle completion pulse
//   value        : register contents
//   an           : active-low one-hot digit enables
//   segments     : active-low {a,b,c,d,e,f,g}
// Build option:
//   LEADING_ZERO_BLANK_EN : blank digits above 0 whose nibble and all higher
//                           nibbles are zero.
module seg7_bitreg_display
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIV_BITS    = 16,
  parameter int BUSY_CYCLES = 2,
  localparam int W          = 4 * DIGITS,
  localparam int IW         = (W > 1) ? $clog2(W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        op,
  input  logic [IW-1:0]     bit_index,
  input  logic              bit_value,
  output logic              valid_out,
  output logic [W-1:0]      value,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        segments
);

  localparam int CW   = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    value_q, value_d;
  logic [IDXW-1:0] digit_idx;
  logic [W-1:0]    shifted;
  logic [3:0]      nibble;

  // Command FSM and register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          state_d = S_BUSY;
          cnt_d   = CW'(BUSY_CYCLES - 1);
          // Out-of-range indices (non-power-of-2 W) still complete the handshake.
          if (int'(bit_index) < W) begin
            case (op_t'(op))
              OP_WRITE:  value_d[bit_index] = bit_value;
              OP_SET:    value_d[bit_index] = 1'b1;
              OP_CLEAR:  value_d[bit_index] = 1'b0;
              OP_TOGGLE: value_d[bit_index] = ~value_q[bit_index];
              default:   value_d = value_q;
            endcase
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  assign ready_out = (state_q == S_IDLE);
  assign valid_out = (state_q == S_DONE);
  assign value     = value_q;

  seg7_scan #(
    .DIGITS   (DIGITS),
    .DIV_BITS (DIV_BITS)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .digit_idx (digit_idx),
    .an        (an)
  );

  // Digit/segment mux: shifting the active nibble down to bit 0 also leaves
  // exactly "this nibble and everything above it" in shifted, which is what
  // leading-zero blanking needs to test.
  always_comb begin
    shifted = value_q >> {digit_idx, 2'b00};
    nibble  = shifted[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit_idx != '0) && (shifted == '0)) begin
      segments = 7'b1111111;
    end else begin
      segments = hex7(nibble);
    end
`else
    segments = hex7(nibble);
`endif
  end

endmodule
